cache_meta_array: RTL and testbench
===================================

Name: cache_meta_array

Overview:
Parametrised tag/valid/LRU metadata store for an N-way set-associative cache. Replaces the fixed 2-way, 64-set metadata array.
- Per lookup, returns a registered hit flag, the one-hot hit way, and a replacement victim.
- Maintains true LRU with per-way age counters.
- Supports line fill, per-set invalidate, and a multi-cycle whole-array flush.
- Sits between the cache controller FSM and the data array; the data array is indexed with hit_way or victim_way.

Parameters:
SETS, 64, number of sets; power of 2, >=2; IDX_W = log2(SETS)
WAYS, 4, associativity; power of 2, 2..8; AGE_W = log2(WAYS)
TAG_W, 7, stored tag width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
lookup_valid  in  1  lookup request this cycle
lookup_index  in  IDX_W  set to look up
lookup_tag  in  TAG_W  tag to compare
rsp_valid  out  1  lookup result valid (one cycle after lookup_valid)
rsp_hit  out  1  tag matched a valid way
rsp_hit_way  out  WAYS  one-hot matching way; 0 on miss
rsp_victim_way  out  WAYS  one-hot replacement candidate
rsp_victim_valid  out  1  victim currently holds a valid line (eviction needed)
fill_valid  in  1  write a tag into a way
fill_index  in  IDX_W  fill set
fill_way  in  WAYS  one-hot fill way
fill_tag  in  TAG_W  tag written
inv_valid  in  1  clear valid bits of all ways in inv_index
inv_index  in  IDX_W  set to invalidate
flush_req  in  1  pulse: clear the whole array
busy  out  1  flush in progress

Behaviour:
- Reset (rst=1 at edge):
  - All valid bits = 0; age[s][w] = w for every set; tags unchanged (don't-care).
  - rsp_valid, rsp_hit, rsp_hit_way, rsp_victim_valid, busy = 0.
  - rsp_victim_way = one-hot way 0.
  - FSM -> IDLE; flush counter = 0.
  - Reset mid-flush aborts the flush; the array is still fully cleared by reset.
- Lookup, latency 1:
  - Request sampled at edge N; rsp_* valid after edge N.
  - rsp_* are registered and hold their value until the next lookup or reset.
  - rsp_valid is a 1-cycle pulse.
  - Compare uses state as it was before edge N.
  - Hit: a way is valid and its tag equals lookup_tag. Multiple matches are illegal; the lowest-index match is reported.
- Victim selection:
  - The lowest-index invalid way; otherwise the way with age == WAYS-1.
  - rsp_victim_valid = 0 if an invalid way was chosen.
  - Reported on both hit and miss.
- LRU touch of way t in set s:
  - Ages are a permutation of 0..WAYS-1 per set at all times.
  - Every way with age < age[t] increments; age[t] becomes 0; all other ages are unchanged.
  - A lookup hit touches the hit way at edge N. Misses do not touch.
- Fill:
  - valid = 1 and tag = fill_tag for fill_way; that way is touched.
  - fill_way must be one-hot; any other encoding is ignored (no state change).
- Invalidate:
  - All valid bits of inv_index are cleared. Ages are reset to age[w] = w.
- Same-cycle priority on one set: inv > fill > lookup-hit touch.
  - The lookup response still reflects pre-edge state.
  - Only the highest-priority update is applied to the shared set.
  - Operations on different sets all apply in the same cycle.
- Flush FSM states:
  - IDLE: flush_req -> FLUSH, with busy = 1 from the next cycle.
  - FLUSH: one set per cycle, counter 0..SETS-1. Each set is cleared like inv. At counter == SETS-1 -> IDLE and busy = 0; counter wraps to 0.
  - Flush takes exactly SETS cycles.
- While busy:
  - lookup_valid still produces rsp_valid, but with rsp_hit = 0 and rsp_victim_valid = 0 (victim = way 0).
  - fill, inv, and flush_req are ignored.
  - flush_req arriving in the same cycle as the final flush step is ignored.
- Storage: registers, not SRAM; combinational read of the indexed set.

Decomposition:
- Package cache_meta_pkg holds:
  - clog2-based width helpers for IDX_W and AGE_W.
  - FSM state enum {IDLE, FLUSH}.
  - One-hot-to-index and index-to-one-hot functions.
- Sub-module cache_lru_age: combinational. Inputs: one set's ages and a touch way. Outputs: next ages and the LRU way.
  - Instantiated once for lookup/fill update and once for victim selection.

Test Plan:
- Reset, then lookup idx 5, tag 0x12 -> rsp_valid=1, rsp_hit=0, rsp_victim_way=0001, rsp_victim_valid=0.
- Fill idx 5 ways 0..3 with tags 0x10..0x13 on consecutive cycles, then lookup tag 0x11 -> rsp_hit=1, rsp_hit_way=0010. A following lookup tag 0x7F -> miss, rsp_victim_way=0001, rsp_victim_valid=1.
- Same state, then hits on ways 0, 2, 3 -> next miss reports victim 0010. Checker confirms ages stay a permutation after every edge.
- Same cycle: fill idx 5 way 1 tag 0x55 and lookup idx 5 tag 0x55 -> that response misses. The next lookup of 0x55 hits on 0010.
- Same cycle: inv idx 5 and fill idx 5 -> set 5 ends fully invalid (inv wins). A fill to idx 6 in that cycle succeeds.
- flush_req with SETS=64 -> busy high for exactly 64 cycles. A fill during busy has no effect, and lookups return miss. After busy falls, every set returns miss with victim 0001. rst asserted at flush cycle 10 -> busy=0 on the next cycle and all sets invalid.

Source files
------------

// File: rtl/cache_meta_pkg.sv
// ---------------------------------------------------------------------------
// cache_meta_pkg
// Shared types and helpers for the cache metadata array.
//   - idx_width / age_width : clog2-based width helpers (minimum 1 bit)
//   - flush_state_t         : flush sequencer states
//   - idx_to_onehot /
//     onehot_to_idx         : way-select encoding helpers (up to MAX_WAYS ways)
// No ports (package).
// ---------------------------------------------------------------------------
package cache_meta_pkg;

  localparam int MAX_WAYS = 8;
  localparam int MAX_WAY_IDX_W = 3;

  typedef enum logic {
    IDLE,
    FLUSH
  } flush_state_t;

  function automatic int idx_width(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int age_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [MAX_WAYS-1:0] idx_to_onehot(input logic [MAX_WAY_IDX_W-1:0] idx);
    logic [MAX_WAYS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Returns the index of the lowest set bit; 0 when no bit is set.
  function automatic logic [MAX_WAY_IDX_W-1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] oh);
    logic [MAX_WAY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (oh[i]) idx = MAX_WAY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_meta_array_if.sv
// ---------------------------------------------------------------------------
// cache_meta_array_if
// Bus between the cache controller (master) and the metadata array (slave).
//   lookup_valid/index/tag          : lookup request
//   rsp_valid/hit/hit_way/
//   rsp_victim_way/victim_valid     : registered lookup response
//   fill_valid/index/way/tag        : line fill (fill_way one-hot)
//   inv_valid/index                 : invalidate one whole set
//   flush_req / busy                : whole-array flush request and status
// ---------------------------------------------------------------------------
interface cache_meta_array_if #(
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int TAG_W = 7
);
  import cache_meta_pkg::*;

  localparam int IDX_W = idx_width(SETS);

  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_index;
  logic [TAG_W-1:0] lookup_tag;

  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAYS-1:0]  rsp_hit_way;
  logic [WAYS-1:0]  rsp_victim_way;
  logic             rsp_victim_valid;

  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [WAYS-1:0]  fill_way;
  logic [TAG_W-1:0] fill_tag;

  logic             inv_valid;
  logic [IDX_W-1:0] inv_index;

  logic             flush_req;
  logic             busy;

  modport master (
    output lookup_valid, lookup_index, lookup_tag,
    output fill_valid, fill_index, fill_way, fill_tag,
    output inv_valid, inv_index, flush_req,
    input  rsp_valid, rsp_hit, rsp_hit_way, rsp_victim_way, rsp_victim_valid,
    input  busy
  );

  modport slave (
    input  lookup_valid, lookup_index, lookup_tag,
    input  fill_valid, fill_index, fill_way, fill_tag,
    input  inv_valid, inv_index, flush_req,
    output rsp_valid, rsp_hit, rsp_hit_way, rsp_victim_way, rsp_victim_valid,
    output busy
  );

endinterface

// File: rtl/cache_lru_age.sv
// ---------------------------------------------------------------------------
// cache_lru_age
// Combinational true-LRU helper for one set.
//   ages_in   : current per-way ages (a permutation of 0..WAYS-1)
//   touch_en  : apply a touch of touch_way
//   touch_way : one-hot way being made most recently used
//   ages_out  : ages after the touch (ages_in when touch_en is low)
//   lru_way   : one-hot way whose age is WAYS-1, from ages_in
// ---------------------------------------------------------------------------
module cache_lru_age
  import cache_meta_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = age_width(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages_in,
  input  logic                       touch_en,
  input  logic [WAYS-1:0]            touch_way,
  output logic [WAYS-1:0][AGE_W-1:0] ages_out,
  output logic [WAYS-1:0]            lru_way
);

  logic [MAX_WAY_IDX_W-1:0] touch_idx;
  logic [AGE_W-1:0]         touch_age;

  // Ways younger than the touched one age by one; the touched way becomes 0.
  // This keeps each set's ages a permutation.
  always_comb begin
    touch_idx = onehot_to_idx(MAX_WAYS'(touch_way));
    touch_age = ages_in[touch_idx[AGE_W-1:0]];
    ages_out  = ages_in;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      lru_way[w] = (ages_in[w] == AGE_W'(WAYS - 1));
      if (touch_en) begin
        if (touch_way[w]) begin
          ages_out[w] = '0;
        end else if (ages_in[w] < touch_age) begin
          ages_out[w] = ages_in[w] + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cache_meta_array.sv
// ---------------------------------------------------------------------------
// cache_meta_array
// Tag/valid/true-LRU metadata store for a WAYS-way, SETS-set cache.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears valids, resets ages, aborts flush)
//   bus  : cache_meta_array_if.slave -- lookup request/response, fill,
//          set invalidate, flush request and busy status
// Lookup responses are registered (one cycle latency) and hold until the
// next lookup. Storage is flip-flops with a combinational read of the set.
// ---------------------------------------------------------------------------
module cache_meta_array
  import cache_meta_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int TAG_W = 7
) (
  input logic              clk,
  input logic              rst,
  cache_meta_array_if.slave bus
);

  localparam int IDX_W = idx_width(SETS);
  localparam int AGE_W = age_width(WAYS);
  localparam logic [MAX_WAYS-1:0] WAY0_FULL = idx_to_onehot(MAX_WAY_IDX_W'(0));
  localparam logic [WAYS-1:0]     WAY0      = WAY0_FULL[WAYS-1:0];

  typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

  function automatic age_vec_t init_ages();
    age_vec_t a;
    for (int w = 0; w < WAYS; w++) a[w] = AGE_W'(w);
    return a;
  endfunction

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  age_vec_t         age_q   [SETS];

  flush_state_t     state_q;
  logic             busy_q;
  logic [IDX_W-1:0] flush_cnt_q;

  logic             rsp_valid_q;
  logic             rsp_hit_q;
  logic [WAYS-1:0]  rsp_hit_way_q;
  logic [WAYS-1:0]  rsp_victim_way_q;
  logic             rsp_victim_valid_q;

  logic             flushing;
  logic [WAYS-1:0]  match;
  logic [WAYS-1:0]  hit_way;
  logic             hit_any;
  logic [WAYS-1:0]  free_ways;
  logic [WAYS-1:0]  first_free;
  logic             look_touch;
  logic             fill_en;
  logic             inv_en;
  age_vec_t         look_ages;
  age_vec_t         fill_ages;
  logic [WAYS-1:0]  look_lru;
  logic [WAYS-1:0]  unused_fill_lru;

  assign flushing = (state_q == FLUSH);

  // Tag compare and free-way search on the looked-up set. x & -x isolates the
  // lowest set bit, giving the lowest-index match / lowest-index free way.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[bus.lookup_index][w] &&
                 (tag_q[bus.lookup_index][w] == bus.lookup_tag);
    end
    hit_way    = match & (~match + WAYS'(1));
    hit_any    = |match;
    free_ways  = ~valid_q[bus.lookup_index];
    first_free = free_ways & (~free_ways + WAYS'(1));
  end

  assign look_touch = bus.lookup_valid && hit_any && !flushing;
  assign fill_en    = bus.fill_valid && $onehot(bus.fill_way) && !flushing;
  assign inv_en     = bus.inv_valid && !flushing;

  // Fill and lookup may target different sets in the same cycle and both
  // updates must land, so each path gets its own age calculator. The lookup
  // instance also supplies the LRU victim of the looked-up set.
  cache_lru_age #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lookup_lru (
    .ages_in   (age_q[bus.lookup_index]),
    .touch_en  (look_touch),
    .touch_way (hit_way),
    .ages_out  (look_ages),
    .lru_way   (look_lru)
  );

  cache_lru_age #(.WAYS(WAYS), .AGE_W(AGE_W)) u_fill_lru (
    .ages_in   (age_q[bus.fill_index]),
    .touch_en  (1'b1),
    .touch_way (bus.fill_way),
    .ages_out  (fill_ages),
    .lru_way   (unused_fill_lru)
  );

  // Per-set valid/age update. Within one set only the highest-priority
  // operation applies: flush step (exclusive), then inv, fill, hit touch.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      if (rst) begin
        valid_q[s] <= '0;
        age_q[s]   <= init_ages();
      end else if (flushing) begin
        if (flush_cnt_q == IDX_W'(s)) begin
          valid_q[s] <= '0;
          age_q[s]   <= init_ages();
        end
      end else if (inv_en && (bus.inv_index == IDX_W'(s))) begin
        valid_q[s] <= '0;
        age_q[s]   <= init_ages();
      end else if (fill_en && (bus.fill_index == IDX_W'(s))) begin
        valid_q[s] <= valid_q[s] | bus.fill_way;
        age_q[s]   <= fill_ages;
      end else if (look_touch && (bus.lookup_index == IDX_W'(s))) begin
        age_q[s]   <= look_ages;
      end
    end
  end

  // Tags are not reset; a tag written into a set that is invalidated in the
  // same cycle is harmless because its valid bit stays clear.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.fill_way[w]) tag_q[bus.fill_index][w] <= bus.fill_tag;
      end
    end
  end

  // Flush sequencer: one set per cycle, SETS cycles in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush_req) begin
            state_q     <= FLUSH;
            busy_q      <= 1'b1;
            flush_cnt_q <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == IDX_W'(SETS - 1)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + IDX_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          flush_cnt_q <= '0;
        end
      endcase
    end
  end

  // Lookup response: pulse rsp_valid, hold the other fields until the next
  // lookup. During a flush the array contents are in transition, so lookups
  // report a miss with an empty way 0 as victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q        <= 1'b0;
      rsp_hit_q          <= 1'b0;
      rsp_hit_way_q      <= '0;
      rsp_victim_way_q   <= WAY0;
      rsp_victim_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        if (flushing) begin
          rsp_hit_q          <= 1'b0;
          rsp_hit_way_q      <= '0;
          rsp_victim_way_q   <= WAY0;
          rsp_victim_valid_q <= 1'b0;
        end else begin
          rsp_hit_q          <= hit_any;
          rsp_hit_way_q      <= hit_way;
          rsp_victim_way_q   <= (|free_ways) ? first_free : look_lru;
          rsp_victim_valid_q <= ~(|free_ways);
        end
      end
    end
  end

  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_hit          = rsp_hit_q;
  assign bus.rsp_hit_way      = rsp_hit_way_q;
  assign bus.rsp_victim_way   = rsp_victim_way_q;
  assign bus.rsp_victim_valid = rsp_victim_valid_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_cache_meta_array.sv
// ---------------------------------------------------------------------------
// tb_cache_meta_array
// Self-checking bench for cache_meta_array (SETS=64, WAYS=4, TAG_W=7).
// Reference model keeps each set's recency as an ordered list of ways
// (front = most recently used) plus valid/tag arrays and a flush countdown.
// ---------------------------------------------------------------------------
module tb_cache_meta_array;

  localparam int SETS  = 64;
  localparam int WAYS  = 4;
  localparam int TAG_W = 7;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_meta_array_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

  cache_meta_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_order [SETS][WAYS];
  int m_flush_left;

  // expected registered response
  int e_rsp_valid, e_hit, e_hit_way, e_victim, e_vv;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic void modelClearSet(input int s);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[s][w] = 1'b0;
      m_order[s][w] = w;
    end
  endfunction

  function automatic void modelTouch(input int s, input int way);
    int p;
    p = 0;
    for (int k = 0; k < WAYS; k++) if (m_order[s][k] == way) p = k;
    for (int k = p; k > 0; k--) m_order[s][k] = m_order[s][k-1];
    m_order[s][0] = way;
  endfunction

  function automatic int wayOf(input int oh);
    for (int w = 0; w < WAYS; w++) if (oh == (1 << w)) return w;
    return -1;
  endfunction

  task automatic applyStimulus(input bit r, input bit lv, input int li, input int lt,
                               input bit fv, input int fi, input int fw, input int ft,
                               input bit iv, input int ii, input bit fr);
    int  hit_w;
    int  fway;
    bit  fill_ok;
    bit  busy_m;
    rst              = r;
    bus.lookup_valid = lv;
    bus.lookup_index = IDX_W'(li);
    bus.lookup_tag   = TAG_W'(lt);
    bus.fill_valid   = fv;
    bus.fill_index   = IDX_W'(fi);
    bus.fill_way     = WAYS'(fw);
    bus.fill_tag     = TAG_W'(ft);
    bus.inv_valid    = iv;
    bus.inv_index    = IDX_W'(ii);
    bus.flush_req    = fr;

    busy_m = (m_flush_left > 0);
    hit_w  = -1;
    if (r) begin
      for (int s = 0; s < SETS; s++) modelClearSet(s);
      m_flush_left = 0;
      e_rsp_valid = 0; e_hit = 0; e_hit_way = 0; e_victim = 1; e_vv = 0;
    end else begin
      e_rsp_valid = lv;
      if (lv) begin
        if (busy_m) begin
          e_hit = 0; e_hit_way = 0; e_victim = 1; e_vv = 0;
        end else begin
          for (int w = WAYS - 1; w >= 0; w--)
            if (m_valid[li][w] && m_tag[li][w] == lt) hit_w = w;
          e_hit     = (hit_w >= 0);
          e_hit_way = (hit_w >= 0) ? (1 << hit_w) : 0;
          e_victim  = 1 << m_order[li][WAYS-1];
          e_vv      = 1;
          for (int w = WAYS - 1; w >= 0; w--) begin
            if (!m_valid[li][w]) begin
              e_victim = 1 << w;
              e_vv     = 0;
            end
          end
        end
      end
      if (busy_m) begin
        modelClearSet(SETS - m_flush_left);
        m_flush_left--;
      end else begin
        fway    = wayOf(fw);
        fill_ok = fv && (fway >= 0);
        if (iv) modelClearSet(ii);
        if (fill_ok && !(iv && ii == fi)) begin
          m_valid[fi][fway] = 1'b1;
          m_tag[fi][fway]   = ft;
          modelTouch(fi, fway);
        end
        if (lv && hit_w >= 0 && !(iv && ii == li) && !(fill_ok && fi == li))
          modelTouch(li, hit_w);
        if (fr) m_flush_left = SETS;
      end
    end

    @(posedge clk);
    #1;
    checkOutput("rsp_valid",        bus.rsp_valid,        e_rsp_valid);
    checkOutput("rsp_hit",          bus.rsp_hit,          e_hit);
    checkOutput("rsp_hit_way",      bus.rsp_hit_way,      e_hit_way);
    checkOutput("rsp_victim_way",   bus.rsp_victim_way,   e_victim);
    checkOutput("rsp_victim_valid", bus.rsp_victim_valid, e_vv);
    checkOutput("busy",             bus.busy,             (m_flush_left > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input int idx, input int tag);
    applyStimulus(0, 1, idx, tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int idx, input int way_oh, input int tag);
    applyStimulus(0, 0, 0, 0, 1, idx, way_oh, tag, 0, 0, 0);
  endtask

  task automatic checkAgesPerm(input string tag, input int s);
    int mask;
    mask = 0;
    for (int w = 0; w < WAYS; w++) mask |= (1 << int'(dut.age_q[s][w]));
    checkOutput(tag, mask, (1 << WAYS) - 1);
  endtask

  initial begin
    int n_busy;
    int guard;

    m_flush_left = 0;
    for (int s = 0; s < SETS; s++) modelClearSet(s);

    // reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_victim", bus.rsp_victim_way, 4'b0001);

    // cold lookup
    lookup(5, 7'h12);
    checkOutput("cold_hit", bus.rsp_hit, 0);
    checkOutput("cold_victim", bus.rsp_victim_way, 4'b0001);
    idle(1);
    checkOutput("rsp_valid_pulse", bus.rsp_valid, 0);

    // fill set 5, then hit and miss
    for (int w = 0; w < WAYS; w++) begin
      fill(5, 1 << w, 7'h10 + w);
      checkAgesPerm("perm_fill", 5);
    end
    lookup(5, 7'h11);
    checkOutput("tp_hit_way", bus.rsp_hit_way, 4'b0010);
    lookup(5, 7'h7F);
    checkOutput("tp_miss_victim", bus.rsp_victim_way, 4'b0001);
    checkOutput("tp_miss_vv", bus.rsp_victim_valid, 1);

    // hits on 0, 2, 3 leave way 1 least recently used
    lookup(5, 7'h10); checkAgesPerm("perm_hit0", 5);
    lookup(5, 7'h12); checkAgesPerm("perm_hit2", 5);
    lookup(5, 7'h13); checkAgesPerm("perm_hit3", 5);
    lookup(5, 7'h70);
    checkOutput("tp_lru_victim", bus.rsp_victim_way, 4'b0010);

    // same-cycle fill + lookup: response reflects pre-edge state
    applyStimulus(0, 1, 5, 7'h55, 1, 5, 4'b0010, 7'h55, 0, 0, 0);
    checkOutput("tp_fill_lookup_miss", bus.rsp_hit, 0);
    lookup(5, 7'h55);
    checkOutput("tp_fill_then_hit", bus.rsp_hit_way, 4'b0010);

    // inv beats fill on the same set; fill to another set proceeds
    applyStimulus(0, 0, 0, 0, 1, 5, 4'b0100, 7'h21, 1, 5, 0);
    lookup(5, 7'h21);
    checkOutput("tp_inv_wins", bus.rsp_hit, 0);
    checkOutput("tp_inv_victim", bus.rsp_victim_way, 4'b0001);
    applyStimulus(0, 0, 0, 0, 1, 6, 4'b0001, 7'h33, 1, 5, 0);
    lookup(6, 7'h33);
    checkOutput("tp_fill_other_set", bus.rsp_hit_way, 4'b0001);

    // non-one-hot fill is ignored
    fill(7, 4'b0011, 7'h44);
    lookup(7, 7'h44);
    checkOutput("tp_bad_fill_way", bus.rsp_hit, 0);

    // flush: busy for exactly SETS cycles, fills ignored, lookups miss
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_busy = bus.busy ? 1 : 0;
    guard  = 0;
    while (bus.busy && guard < 4 * SETS) begin
      if (guard == 3) applyStimulus(0, 0, 0, 0, 1, 9, 4'b0001, 7'h66, 0, 0, 0);
      else if (guard == SETS - 2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else applyStimulus(0, 1, 6, 7'h33, 0, 0, 0, 0, 0, 0, 0);
      if (bus.busy) n_busy++;
      guard++;
    end
    checkOutput("flush_len", n_busy, SETS);
    for (int s = 0; s < SETS; s++) begin
      lookup(s, (s == 9) ? 7'h66 : 7'h33);
      checkOutput("post_flush_victim", bus.rsp_victim_way, 4'b0001);
    end

    // reset in the middle of a flush
    for (int s = 0; s < 8; s++) fill(s, 1 << (s % WAYS), s);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(10);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_flush_busy", bus.busy, 0);
    for (int s = 0; s < 8; s++) lookup(s, s);

    // randomized traffic on a few sets with a small tag space
    for (int i = 0; i < 3000; i++) begin
      bit r, lv, fv, iv, fr;
      int fw;
      r  = ($urandom % 500) == 0;
      lv = ($urandom % 10) < 6;
      fv = ($urandom % 10) < 4;
      iv = ($urandom % 20) == 0;
      fr = ($urandom % 400) == 0;
      fw = (($urandom % 8) == 0) ? int'($urandom % 16) : (1 << ($urandom % WAYS));
      applyStimulus(r, lv, $urandom % 8, $urandom % 8, fv, $urandom % 8, fw,
                    $urandom % 8, iv, $urandom % 8, fr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
